// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports with a req/ack sequencer.
// Optional fetch starvation guard is compiled in with `define ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  core_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT_I = 2'd1,
        S_GRANT_D = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    state_t                  r_state;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic [DATA_WIDTH-1:0]   r_if_rdata;
    logic [DATA_WIDTH-1:0]   r_d_rdata;
    logic                    r_if_valid;
    logic                    r_d_valid;

    logic                    w_starved;
    logic                    w_data_wins;
    logic                    w_fetch_wins;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt == LP_LIMIT);

    // Counts data grants that overtook a waiting fetch; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (w_fetch_wins || !if_req) begin
                r_starve_cnt <= 4'd0;
            end else if (w_data_wins && r_starve_cnt != LP_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    // Data is the older instruction and wins ties unless fetch has been starved.
    assign w_data_wins  = d_req && !(if_req && w_starved);
    assign w_fetch_wins = if_req && !w_data_wins;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_data_wins) begin
                        r_state     <= S_GRANT_D;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= d_we;
                        r_mem_addr  <= d_addr;
                        r_mem_wdata <= d_wdata;
                    end else if (w_fetch_wins) begin
                        r_state    <= S_GRANT_I;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= if_addr;
                    end
                end
                S_GRANT_I: begin
                    if (mem_ack) begin
                        r_state    <= S_DONE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                        r_if_rdata <= mem_rdata;
                        r_if_valid <= 1'b1;
                    end
                end
                S_GRANT_D: begin
                    if (mem_ack) begin
                        r_state   <= S_DONE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_d_valid <= 1'b1;
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_if_valid <= 1'b0;
                    r_d_valid  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign if_rdata   = r_if_rdata;
    assign d_rdata    = r_d_rdata;
    assign if_valid   = r_if_valid;
    assign d_valid    = r_d_valid;
    assign core_stall = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected grants and read data are queued by the
// stimulus and popped by a negedge monitor; a small memory model answers mem_req.
`timescale 1ns/1ps
module tb_unified_mem_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          core_stall;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    unified_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .core_stall(core_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } grant_t;

    grant_t        exp_grant_q[$];
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_d_q[$];
    int            checks = 0;
    int            errors = 0;
    int            grant_cnt = 0;
    logic [DW-1:0] mem_model [logic [AW-1:0]];
    int            wait_cfg = 0;
    bit            mem_auto = 1'b1;
    int            wait_cnt = 0;
    logic          prev_mem_req = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    task automatic wait_valid(input bit is_d, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!(is_d ? d_valid : if_valid) && cycles < 60);
        if (!(is_d ? d_valid : if_valid)) timeout_fail(is_d ? "wait_d_valid" : "wait_if_valid");
    endtask

    // Memory model: acks after wait_cfg cycles of mem_req.
    always @(negedge clk) begin
        if (mem_auto) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wait_cnt == wait_cfg) begin
                    mem_ack  = 1'b1;
                    wait_cnt = 0;
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : '0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        grant_t g;
        logic [DW-1:0] e;
        if (mem_req && !prev_mem_req) begin
            grant_cnt++;
            checks++;
            if (exp_grant_q.size() == 0) begin
                errors++;
                $display("FAIL grant unexpected we=%0b addr=%0h", mem_we, mem_addr);
            end else begin
                g = exp_grant_q.pop_front();
                if (grant_t'({mem_we, mem_addr, mem_wdata}) !== g) begin
                    errors++;
                    $display("FAIL grant actual we=%0b addr=%0h wdata=%0h required we=%0b addr=%0h wdata=%0h",
                             mem_we, mem_addr, mem_wdata, g.we, g.addr, g.wdata);
                end
            end
        end
        prev_mem_req = mem_req;
        if (if_valid) begin
            checks++;
            if (exp_if_q.size() == 0) begin
                errors++;
                $display("FAIL if_valid unexpected if_rdata=%0h", if_rdata);
            end else begin
                e = exp_if_q.pop_front();
                if (if_rdata !== e) begin
                    errors++;
                    $display("FAIL if_rdata actual=%0h required=%0h", if_rdata, e);
                end
            end
        end
        if (d_valid) begin
            checks++;
            if (exp_d_q.size() == 0) begin
                errors++;
                $display("FAIL d_valid unexpected d_rdata=%0h", d_rdata);
            end else begin
                e = exp_d_q.pop_front();
                if (d_rdata !== e) begin
                    errors++;
                    $display("FAIL d_rdata actual=%0h required=%0h", d_rdata, e);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_mem_req"}, 64'(mem_req), 64'd0);
        check({name, "_mem_we"}, 64'(mem_we), 64'd0);
        check({name, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({name, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({name, "_if_rdata"}, 64'(if_rdata), 64'd0);
        check({name, "_d_rdata"}, 64'(d_rdata), 64'd0);
        check({name, "_valids"}, 64'({if_valid, d_valid}), 64'd0);
    endtask

    initial begin
        int cyc;
        int we_cnt;
        int g0;
        rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0; mem_ack = 1'b0;
        mem_model[32'h100]  = 32'h0050_0093;
        mem_model[32'h104]  = 32'h1122_3344;
        mem_model[32'h108]  = 32'h0000_BEEF;
        mem_model[32'h3000] = 32'hCAFE_0001;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        check("reset_stall", 64'(core_stall), 64'd0);

        // Zero-wait fetch.
        @(posedge clk); #1;
        exp_grant_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_if_q.push_back(32'h0050_0093);
        if_req = 1'b1; if_addr = 32'h100;
        #1 check("fetch_stall_req", 64'(core_stall), 64'd1);
        wait_valid(1'b0, cyc);
        check("fetch_latency", 64'(cyc), 64'd2);
        check("fetch_stall_valid", 64'(core_stall), 64'd0);
        check("fetch_memreq_dropped", 64'(mem_req), 64'd0);
        @(posedge clk); #1 if_req = 1'b0;

        // Store with 3 wait cycles.
        wait_cfg = 3;
        exp_grant_q.push_back('{we: 1'b1, addr: 32'h2000, wdata: 32'hDEAD_BEEF});
        exp_d_q.push_back(32'h0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF;
        we_cnt = 0; cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (mem_we) we_cnt++;
        end while (!d_valid && cyc < 60);
        if (!d_valid) timeout_fail("store_d_valid");
        check("store_we_cycles", 64'(we_cnt), 64'd4);
        @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        check("store_valid_pulse", 64'(d_valid), 64'd0);

        // Simultaneous fetch and load: data first.
        wait_cfg = 0;
        @(posedge clk); #1;
        exp_grant_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0});
        exp_grant_q.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'h0});
        exp_d_q.push_back(32'hDEAD_BEEF);
        exp_if_q.push_back(32'h1122_3344);
        d_req = 1'b1; d_addr = 32'h2000; if_req = 1'b1; if_addr = 32'h104;
        wait_valid(1'b1, cyc);
        check("both_loser_stall", 64'(core_stall), 64'd1);
        check("both_no_if_valid", 64'(if_valid), 64'd0);
        @(posedge clk); #1 d_req = 1'b0;
        wait_valid(1'b0, cyc);
        @(posedge clk); #1 if_req = 1'b0;

        // Both held continuously: starvation behaviour.
        @(posedge clk); #1;
`ifdef ARB_STARVE_GUARD_EN
        for (int k = 0; k < 6; k++) begin
            if (k == 2 || k == 5) begin
                exp_grant_q.push_back('{we: 1'b0, addr: 32'h108, wdata: 32'h0});
                exp_if_q.push_back(32'h0000_BEEF);
            end else begin
                exp_grant_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0});
                exp_d_q.push_back(32'hCAFE_0001);
            end
        end
`else
        for (int k = 0; k < 6; k++) begin
            exp_grant_q.push_back('{we: 1'b0, addr: 32'h3000, wdata: 32'h0});
            exp_d_q.push_back(32'hCAFE_0001);
        end
`endif
        g0 = grant_cnt;
        d_req = 1'b1; d_addr = 32'h3000; if_req = 1'b1; if_addr = 32'h108;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (grant_cnt < g0 + 6 && cyc < 200);
        if (grant_cnt < g0 + 6) timeout_fail("starve_grants");
        cyc = 0;
        while (!(if_valid || d_valid) && cyc < 60) begin @(negedge clk); cyc++; end
        if (!(if_valid || d_valid)) timeout_fail("starve_last_valid");
        @(posedge clk); #1 d_req = 1'b0; if_req = 1'b0;
        repeat (3) @(negedge clk);
        check("starve_grant_total", 64'(grant_cnt - g0), 64'd6);

        // Reset during GRANT_D, late ack afterwards.
        mem_auto = 1'b0;
        mem_ack = 1'b0;
        exp_grant_q.push_back('{we: 1'b0, addr: 32'h2000, wdata: 32'h0});
        @(posedge clk); #1 d_req = 1'b1; d_addr = 32'h2000;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!mem_req && cyc < 20);
        if (!mem_req) timeout_fail("rst_wait_mem_req");
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        mem_ack = 1'b1; mem_rdata = 32'h0000_0055; rst = 1'b0;
        @(negedge clk);
        mem_ack = 1'b0;
        check("late_ack_d_valid", 64'(d_valid), 64'd0);
        check("late_ack_d_rdata", 64'(d_rdata), 64'd0);
        check("late_ack_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("late_ack_d_valid2", 64'(d_valid), 64'd0);

        // Spurious ack while idle.
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idle_ack_valids", 64'({if_valid, d_valid}), 64'd0);
        check("idle_ack_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        check("idle_ack_valids2", 64'({if_valid, d_valid}), 64'd0);
        mem_auto = 1'b1;

        // Idle ack must not disturb a following fetch.
        @(posedge clk); #1;
        exp_grant_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
        exp_if_q.push_back(32'h0050_0093);
        if_req = 1'b1; if_addr = 32'h100;
        wait_valid(1'b0, cyc);
        check("post_idle_fetch_latency", 64'(cyc), 64'd2);
        @(posedge clk); #1 if_req = 1'b0;

        repeat (4) @(negedge clk);
        check("left_grants", 64'(exp_grant_q.size()), 64'd0);
        check("left_if", 64'(exp_if_q.size()), 64'd0);
        check("left_d", 64'(exp_d_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the core's instruction-fetch port and its data (load/store) port. It sits between the pipelined core and the memory. It accepts one request at a time from each side, issues it to memory with a req/ack handshake, and returns the read data with a one-cycle valid pulse. It also drives a stall that the core uses to freeze its pipeline registers while an access is outstanding.

## Interface
- DATA_WIDTH, 32, width of instruction and data words
- ADDR_WIDTH, 32, width of all addresses
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (used only when the guard is compiled in; legal range 1–15)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_WIDTH  fetch address (PC)
- if_rdata  out  DATA_WIDTH  fetched instruction, registered
- if_valid  out  1  one-cycle pulse: fetch done, if_rdata valid
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data, registered
- d_valid  out  1  one-cycle pulse: data access done
- core_stall  out  1  combinational: (if_req & ~if_valid) | (d_req & ~d_valid)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_WIDTH  memory address, registered
- mem_wdata  out  DATA_WIDTH  memory write data, registered
- mem_rdata  in  DATA_WIDTH  memory read data, valid in the mem_ack cycle
- mem_ack  in  1  memory completion, one cycle

## Operation
- FSM states:
  - IDLE → GRANT_I or GRANT_D when the corresponding request wins.
  - GRANT_I / GRANT_D → DONE on mem_ack.
  - DONE → IDLE unconditionally.
- Arbitration is evaluated in IDLE only:
  - d_req alone: data wins.
  - if_req alone: fetch wins.
  - Both: data wins (the load/store is the older instruction), except as modified by the starvation guard.
- On grant, the next edge loads mem_addr/mem_we/mem_wdata from the winner and sets mem_req=1. For a fetch, mem_we=0 and mem_wdata is unchanged.
- In GRANT_x, mem_req and all mem_* outputs hold until the edge that samples mem_ack=1. That edge:
  - clears mem_req and mem_we;
  - captures mem_rdata into if_rdata (fetch) or d_rdata (load); a store leaves d_rdata unchanged.
- DONE pulses the matching valid for exactly one cycle. Requests are not sampled in DONE.
- A requester drops or changes req in the cycle after its valid. A req still high in IDLE is treated as a new access.
- mem_ack while in IDLE or DONE is ignored.

## Timing
- Reset values: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, d_rdata=0, if_valid=0, d_valid=0, state=IDLE, starve counter=0.
- Latency with zero-wait memory:
  - req sampled in IDLE at cycle 0;
  - mem_req=1 at cycle 1, mem_ack=1 in the same cycle;
  - valid=1 at cycle 2;
  - IDLE at cycle 3.
- Throughput: one access per 3 cycles plus memory wait cycles.
- core_stall stays high from req assertion through the cycle before valid, and is low in the valid cycle.
- Reset mid-operation: the next edge returns to IDLE with all outputs at reset values. The outstanding memory access is abandoned, and a late mem_ack is ignored.
- Simultaneous if_req and d_req arriving at IDLE are resolved in that same cycle. The loser stays pending with core_stall=1 and is served on the next IDLE.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - a 4-bit counter increments on each data grant made while if_req=1, saturating at STARVE_LIMIT;
  - it clears on any fetch grant, or in IDLE when if_req=0;
  - while the counter equals STARVE_LIMIT and both requests are pending, fetch wins.
- ARB_STARVE_GUARD_EN undefined: the counter is absent and data priority is strict.

## Test plan
- Reset, then if_req=1, if_addr=0x100, mem_ack in the first mem_req cycle, mem_rdata=0x00500093 → mem_addr=0x100, mem_we=0; if_valid at cycle 2 with if_rdata=0x00500093; core_stall low at cycle 2.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, memory acks after 3 wait cycles → mem_we=1 held for 4 cycles; d_valid one cycle; d_rdata unchanged.
- Simultaneous if_req (0x104) and load d_req (0x2000) → data granted first, d_valid, then fetch granted at the next IDLE; if_valid follows.
- With ARB_STARVE_GUARD_EN and STARVE_LIMIT=2, d_req held continuously and if_req pending → grant order D, D, I, D, D, I. Without the macro → D only, until d_req drops.
- rst asserted during GRANT_D with mem_ack arriving one cycle after rst → all outputs 0 on the next edge, no d_valid, FSM in IDLE.
- mem_ack pulsed while idle with no requests → no valid pulse, no state change.
